hiscore_ram_arbiter: RTL and testbench
======================================

// Module: hiscore_ram_arbiter
// PURPOSE
// - Shares the game core's single work-RAM port between the CPU and the hiscore save/restore engine.
// - On a hiscore request it halts the CPU through the pause path and waits for the halt acknowledge.
// - It then switches the RAM port to the hiscore engine, and releases the CPU after a fixed holdoff.
// - Sits between the hiscore engine, the core's pause input and the work-RAM instance.
// PARAMETERS
// - AW            16    RAM address width
// - DW            8     RAM data width
// - HALT_TIMEOUT  1024  clk_sys cycles to wait for halt_ack before forcing the grant; 0 = wait forever
// - HOLDOFF       4     clk_sys cycles the pause is held after the hiscore engine drops its request
// PORTS
// - clk_sys      in   1   system clock, 48 MHz
// - reset_n      in   1   asynchronous reset, active low
// - hs_req       in   1   hiscore engine requests the RAM (level)
// - hs_addr      in   AW  hiscore address
// - hs_wdata     in   DW  hiscore write data
// - hs_we        in   1   hiscore write strobe, 1 cycle
// - hs_grant     out  1   RAM port is owned by the hiscore engine
// - hs_rdata     out  DW  read data for the hiscore engine
// - cpu_addr     in   AW  CPU address
// - cpu_wdata    in   DW  CPU write data
// - cpu_we       in   1   CPU write strobe
// - cpu_rdata    out  DW  read data for the CPU
// - halt_req     out  1   to the core pause input; OR it externally with the user/OSD pause
// - halt_ack     in   1   CPU is stopped at a bus-idle boundary
// - ram_addr     out  AW  RAM address
// - ram_wdata    out  DW  RAM write data
// - ram_we       out  1   RAM write enable
// - ram_rdata    in   DW  RAM read data, 1-cycle synchronous read
// BEHAVIOUR
// - Reset values: halt_req=0, hs_grant=0, ram_we=0, state=IDLE, counters=0, hs_rdata=0.
// - On reset the RAM mux selects the CPU.
// - IDLE: the mux selects the CPU.
//   - hs_req=1 -> HALT_WAIT and halt_req<=1 on the next edge.
// - HALT_WAIT: halt_req=1; the timeout counter increments every cycle.
//   - halt_ack=1, or count==HALT_TIMEOUT-1 (when HALT_TIMEOUT!=0) -> GRANT.
//   - hs_req drops before the grant -> HOLDOFF; the hiscore engine never gets the port.
// - GRANT: hs_grant=1 and the mux selects the hiscore inputs.
//   - ram_we = hs_we.
//   - cpu_we is masked to 0 even if the CPU misbehaves.
//   - hs_rdata <= ram_rdata every cycle. Read data is valid 1 cycle after hs_addr is presented.
//   - hs_req=0 -> HOLDOFF; hs_grant<=0 on the same edge.
// - HOLDOFF: the mux returns to the CPU while halt_req is still 1.
//   - After HOLDOFF cycles: halt_req<=0 -> IDLE.
//   - hs_req re-asserted during HOLDOFF -> GRANT directly, without re-waiting for the ack.
// - The mux select is registered from the state, so the port switches on a clock edge.
//   - A hiscore write is never issued in the same cycle the select changes.
//   - hs_grant is a registered copy of the select.
// - cpu_rdata = ram_rdata at all times. It is only meaningful while the CPU owns the port.
// - halt_ack falling during GRANT is ignored; the grant is kept until hs_req drops.
// - The timeout counter saturates. It is cleared on entry to HALT_WAIT.
// - The holdoff counter is cleared on entry to HOLDOFF.
// - Asynchronous reset in any state returns to the reset values immediately.
//   - A hiscore write in flight is dropped.
// STRUCTURE
// - Shared package entries:
//   - state enum {IDLE, HALT_WAIT, GRANT, HOLDOFF}, 2 bits
//   - HS_AW and HS_DW default constants
// - One natural sub-module: hiscore_ram_mux, a registered 2:1 RAM port mux with write-enable gating.
// - The FSM and the counters stay in the top of this block.
// TESTING
// - Reset: hold reset_n=0 -> halt_req=0, hs_grant=0, ram_we=0, ram_addr==cpu_addr.
// - Normal grant:
//   - Stimulus: hs_req=1; halt_ack rises 5 cycles later.
//   - Required: halt_req=1 one cycle after hs_req; hs_grant=1 on the cycle after the ack.
//   - Required: hs_we with addr 16'h0C00, data 8'hA5 -> ram_we=1 and RAM[0C00]=A5.
// - Timeout: HALT_TIMEOUT=16, halt_ack held at 0 -> hs_grant=1 exactly 16 cycles after HALT_WAIT entry.
// - Release:
//   - Stimulus: drop hs_req in GRANT.
//   - Required: hs_grant=0 next cycle; halt_req stays 1 for 4 more cycles, then 0.
//   - Required: a cpu_we after release writes the RAM.
// - Re-request: re-assert hs_req on holdoff cycle 2 -> GRANT next cycle with halt_req never dropping.
// - Isolation and readback:
//   - Stimulus: cpu_we=1 with cpu_addr 16'h0C00 during GRANT.
//   - Required: RAM unchanged.
//   - Required: a hiscore read of 0C00 returns A5 one cycle later.

Source files
------------

// File: rtl/hiscore_ram_arbiter_pkg.sv
// Shared types and defaults for the hiscore work-RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hiscore_ram_arbiter_pkg;

    localparam int HS_AW = 16;
    localparam int HS_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HALT_WAIT = 2'd1,
        ST_GRANT     = 2'd2,
        ST_HOLDOFF   = 2'd3
    } hs_state_t;

endpackage

// File: rtl/hiscore_ram_mux.sv
// Registered-select 2:1 work-RAM port mux (CPU / hiscore engine) with write gating.
// Latency: select takes effect one clk_sys edge after sel_d; hs_rdata is ram_rdata retimed by one register.
// Backpressure: none; writes are dropped in any cycle where the select is about to change.
// Ports:
//   sel_d          next owner (1 = hiscore), registered into sel_q
//   hs_* / cpu_*   requester address, write data and write strobe
//   ram_*          shared RAM port; ram_rdata is the RAM's synchronous read data
//   sel_q          current owner, also used as the hiscore grant
//   hs_rdata       read data returned to the hiscore engine
module hiscore_ram_mux
    import hiscore_ram_arbiter_pkg::*;
#(
    parameter int AW = HS_AW,
    parameter int DW = HS_DW
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          sel_d,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          sel_q,
    output logic [DW-1:0] hs_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we
);

    logic sel_changing;

    assign sel_changing = sel_d ^ sel_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sel_q    <= 1'b0;
            hs_rdata <= '0;
        end else begin
            sel_q <= sel_d;
            if (sel_q) begin
                hs_rdata <= ram_rdata;
            end
        end
    end

    // A write on the edge where ownership flips would be attributed to the
    // wrong requester, so both strobes are suppressed for that cycle.
    always_comb begin
        ram_addr  = sel_q ? hs_addr  : cpu_addr;
        ram_wdata = sel_q ? hs_wdata : cpu_wdata;
        ram_we    = 1'b0;
        if (!sel_changing) begin
            ram_we = sel_q ? hs_we : cpu_we;
        end
    end

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Shares the core work-RAM port between the CPU and the hiscore engine, halting the CPU around hiscore access.
// Latency: halt_req one cycle after hs_req; grant one cycle after halt_ack (or timeout); CPU released HOLDOFF cycles after hs_req drops.
// Backpressure: hs_req is held until hs_grant; the CPU is stalled via halt_req while the port is handed over.
// Ports:
//   clk_sys, reset_n       system clock, asynchronous active-low reset
//   hs_req/addr/wdata/we   hiscore engine request and access; hs_grant, hs_rdata back
//   cpu_addr/wdata/we      CPU access; cpu_rdata back
//   halt_req, halt_ack     pause request to the core and its bus-idle acknowledge
//   ram_addr/wdata/we      shared RAM port; ram_rdata 1-cycle synchronous read data
module hiscore_ram_arbiter
    import hiscore_ram_arbiter_pkg::*;
#(
    parameter int AW           = HS_AW,
    parameter int DW           = HS_DW,
    parameter int HALT_TIMEOUT = 1024,
    parameter int HOLDOFF      = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_we,
    output logic          hs_grant,
    output logic [DW-1:0] hs_rdata,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_rdata,
    output logic          halt_req,
    input  logic          halt_ack,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    localparam int TW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((HALT_TIMEOUT > 0) ? HALT_TIMEOUT - 1 : 0);
    localparam logic [HW-1:0] HO_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    hs_state_t     state;
    logic [TW-1:0] to_cnt;
    logic [HW-1:0] ho_cnt;
    logic          timeout_hit;
    logic          holdoff_done;
    logic          grant_nxt;

    assign timeout_hit  = (HALT_TIMEOUT != 0) && (to_cnt == TO_LAST);
    assign holdoff_done = (ho_cnt >= HO_LAST);
    assign cpu_rdata    = ram_rdata;

    // Next-cycle ownership. Feeds the mux's select register so the port and
    // hs_grant switch on the same edge as the state. A re-request during
    // HOLDOFF skips the ack wait: the CPU has not been released yet.
    always_comb begin
        grant_nxt = 1'b0;
        case (state)
            ST_HALT_WAIT: grant_nxt = hs_req && (halt_ack || timeout_hit);
            ST_GRANT:     grant_nxt = hs_req;
            ST_HOLDOFF:   grant_nxt = hs_req;
            default:      grant_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            halt_req <= 1'b0;
            to_cnt   <= '0;
            ho_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs_req) begin
                        state    <= ST_HALT_WAIT;
                        halt_req <= 1'b1;
                        to_cnt   <= '0;
                    end
                end
                ST_HALT_WAIT: begin
                    if (to_cnt != '1) begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                    // Abandoned request: the engine never sees the port.
                    if (!hs_req) begin
                        state  <= ST_HOLDOFF;
                        ho_cnt <= '0;
                    end else if (grant_nxt) begin
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // halt_ack is deliberately ignored here.
                    if (!hs_req) begin
                        state  <= ST_HOLDOFF;
                        ho_cnt <= '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (hs_req) begin
                        state <= ST_GRANT;
                    end else if (holdoff_done) begin
                        state    <= ST_IDLE;
                        halt_req <= 1'b0;
                    end else begin
                        ho_cnt <= ho_cnt + HW'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    halt_req <= 1'b0;
                end
            endcase
        end
    end

    hiscore_ram_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .sel_d     (grant_nxt),
        .hs_addr   (hs_addr),
        .hs_wdata  (hs_wdata),
        .hs_we     (hs_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .ram_rdata (ram_rdata),
        .sel_q     (hs_grant),
        .hs_rdata  (hs_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we)
    );

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter with a behavioural synchronous work RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_hiscore_ram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        hs_req;
    logic [15:0] hs_addr;
    logic [7:0]  hs_wdata;
    logic        hs_we;
    logic        hs_grant;
    logic [7:0]  hs_rdata;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic        halt_req;
    logic        halt_ack;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_sys = ~clk_sys;

    // Work RAM: write-first is irrelevant here, reads return the old word.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    hiscore_ram_arbiter #(
        .AW(16),
        .DW(8),
        .HALT_TIMEOUT(16),
        .HOLDOFF(4)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .hs_req    (hs_req),
        .hs_addr   (hs_addr),
        .hs_wdata  (hs_wdata),
        .hs_we     (hs_we),
        .hs_grant  (hs_grant),
        .hs_rdata  (hs_rdata),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .halt_req  (halt_req),
        .halt_ack  (halt_ack),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        hs_req    = 1'b0;
        hs_addr   = 16'h0000;
        hs_wdata  = 8'h00;
        hs_we     = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        halt_ack  = 1'b0;

        // Reset
        step();
        step();
        chk("rst_halt_req", halt_req, 1'b0);
        chk("rst_hs_grant", hs_grant, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 16'h1234);
        chk("rst_hs_rdata", hs_rdata, 8'h00);
        reset_n = 1'b1;
        step();

        // CPU preloads 0C00 and 0200 so later writes are visible as changes
        cpu_addr = 16'h0C00; cpu_wdata = 8'h11; cpu_we = 1'b1;
        #1 chk("cpu_pre_we", ram_we, 1'b1);
        step();
        cpu_addr = 16'h0200; cpu_wdata = 8'h3C;
        step();
        cpu_we = 1'b0;
        chk("cpu_pre_mem", mem[16'h0C00], 8'h11);

        // Normal grant: ack arrives 5 cycles after the request
        hs_req = 1'b1; hs_addr = 16'h0C00; hs_wdata = 8'hA5;
        step();
        chk("ng_halt_req", halt_req, 1'b1);
        chk("ng_grant_early", hs_grant, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ng_wait_grant", hs_grant, 1'b0);
        end
        halt_ack = 1'b1;
        step();
        chk("ng_grant", hs_grant, 1'b1);
        chk("ng_addr_sel", ram_addr, 16'h0C00);
        hs_we = 1'b1;
        #1 chk("ng_ram_we", ram_we, 1'b1);
        step();
        hs_we = 1'b0;
        chk("ng_mem_a5", mem[16'h0C00], 8'hA5);

        // Isolation: CPU write during GRANT, ack dropping is ignored
        halt_ack = 1'b0;
        cpu_addr = 16'h0C00; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        #1 chk("iso_ram_we", ram_we, 1'b0);
        step();
        cpu_we = 1'b0;
        chk("iso_mem", mem[16'h0C00], 8'hA5);
        chk("iso_grant_kept", hs_grant, 1'b1);

        // Readback: RAM data one cycle after the address, retimed into hs_rdata
        hs_addr = 16'h0200;
        step();
        step();
        chk("rb_other", hs_rdata, 8'h3C);
        hs_addr = 16'h0C00;
        step();
        chk("rb_ram_data", cpu_rdata, 8'hA5);
        step();
        chk("rb_hs_rdata", hs_rdata, 8'hA5);

        // Release: grant drops next cycle, pause held 4 more cycles
        hs_req = 1'b0;
        step();
        chk("rel_grant", hs_grant, 1'b0);
        chk("rel_addr_cpu", ram_addr, 16'h0C00 & cpu_addr);
        for (int i = 0; i < 4; i++) begin
            chk("rel_halt_held", halt_req, 1'b1);
            step();
        end
        chk("rel_halt_drop", halt_req, 1'b0);
        cpu_addr = 16'h0C00; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        step();
        cpu_we = 1'b0;
        chk("rel_cpu_write", mem[16'h0C00], 8'h5A);

        // Timeout: no ack, grant 16 cycles after HALT_WAIT entry
        hs_req = 1'b1;
        step();
        chk("to_halt_req", halt_req, 1'b1);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("to_wait", hs_grant, 1'b0);
        end
        step();
        chk("to_grant", hs_grant, 1'b1);

        // Re-request on holdoff cycle 2
        hs_req = 1'b0;
        step();
        chk("rr_grant_off", hs_grant, 1'b0);
        step();
        chk("rr_halt_c2", halt_req, 1'b1);
        hs_req = 1'b1;
        step();
        chk("rr_grant", hs_grant, 1'b1);
        chk("rr_halt", halt_req, 1'b1);

        // Let it return to IDLE
        hs_req = 1'b0;
        repeat (5) step();
        chk("rr_idle_halt", halt_req, 1'b0);

        // Abandoned request before the grant goes through HOLDOFF only
        hs_req = 1'b1;
        step();
        hs_req = 1'b0;
        step();
        chk("ab_no_grant", hs_grant, 1'b0);
        chk("ab_halt", halt_req, 1'b1);
        repeat (4) step();
        chk("ab_idle", halt_req, 1'b0);

        // Asynchronous reset during a hiscore write
        hs_req = 1'b1;
        step();
        halt_ack = 1'b1;
        step();
        chk("ar_grant", hs_grant, 1'b1);
        hs_addr = 16'h0C02; hs_wdata = 8'h77; hs_we = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("ar_grant_off", hs_grant, 1'b0);
        chk("ar_halt_off", halt_req, 1'b0);
        chk("ar_ram_we", ram_we, 1'b0);
        hs_we = 1'b0; hs_req = 1'b0; halt_ack = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
